// File: rtl/pe_config_pkg.sv
// pe_config_pkg: shared widths, sequencer state encoding and the buffered config word type.
// READ/CHECK states exist only when PE_CONFIG_READBACK_EN is defined.
package pe_config_pkg;
  localparam int CFG_ADDR_W = 32;
  localparam int CFG_DATA_W = 32;
  localparam int WORD_COUNT_W = 16;
  typedef enum logic [2:0] {
    IDLE, TRST, WAIT, WRITE, SETTLE, DONE
`ifdef PE_CONFIG_READBACK_EN
    , READ, CHECK
`endif
  } cfg_seq_state_t;
  typedef struct packed {
    logic [CFG_ADDR_W-1:0] addr;
    logic [CFG_DATA_W-1:0] data;
    logic                  last;
  } cfg_word_t;
endpackage

// File: rtl/pe_config_fifo.sv
// pe_config_fifo: DEPTH-entry synchronous FIFO of config words; extra-MSB pointers give full/empty/count.
module pe_config_fifo
  import pe_config_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  cfg_word_t              wr_word,
  output cfg_word_t              rd_word,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  cfg_word_t mem [DEPTH];
  logic [AW:0] wptr, rptr;
  assign count = wptr - rptr;
  assign empty = wptr == rptr;
  assign full = count == DEPTH[AW:0];
  assign rd_word = mem[rptr[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) wptr <= wptr + 1'b1;
      if (pop && !empty) rptr <= rptr + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (push && !full) mem[wptr[AW-1:0]] <= wr_word;
  end
endmodule

// File: rtl/pe_config_sequencer.sv
// pe_config_sequencer: pulses tile reset, then replays buffered (addr,data) words onto the tile config bus.
// PE_CONFIG_READBACK_EN adds a read-back of every written word that flags mismatches in error.
module pe_config_sequencer
  import pe_config_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int SETTLE_CYCLES = 1,
  parameter int TILE_RST_CYCLES = 3
) (
  input  logic                    clk_in,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [CFG_ADDR_W-1:0]   cfg_addr,
  input  logic [CFG_DATA_W-1:0]   cfg_data,
  input  logic                    cfg_last,
  output logic                    tile_reset,
  output logic [CFG_ADDR_W-1:0]   config_addr,
  output logic [CFG_DATA_W-1:0]   config_data,
  output logic                    config_write,
  output logic                    config_read,
  input  logic [CFG_DATA_W-1:0]   read_data,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [WORD_COUNT_W-1:0] word_count
);
  localparam int AW = $clog2(DEPTH);
  cfg_seq_state_t state;
  cfg_word_t wr_word, rd_word;
  logic full, empty, push, pop, go, last_seen, last_next, cur_last;
  logic [AW:0] count, cnt_next;
  logic [15:0] tmr;
  assign wr_word = '{addr: cfg_addr, data: cfg_data, last: cfg_last};
  assign push = cfg_valid && cfg_ready && !full;
  assign pop = state == WAIT && !empty;
  assign go = start && (state == IDLE || state == DONE);
  assign cnt_next = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  assign last_next = last_seen || (push && cfg_last);
  pe_config_fifo #(.DEPTH(DEPTH)) fifo (
    .clk(clk_in), .rst_n(reset), .push(push), .pop(pop), .wr_word(wr_word),
    .rd_word(rd_word), .full(full), .empty(empty), .count(count)
  );
`ifndef PE_CONFIG_READBACK_EN
  logic unused_read;
  assign unused_read = ^read_data;
  assign config_read = 1'b0;
`endif
  // cfg_ready is registered, so it is computed from the FIFO occupancy after this edge
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      tmr <= '0;
      last_seen <= 1'b0;
      cur_last <= 1'b0;
      cfg_ready <= 1'b0;
      tile_reset <= 1'b0;
      config_addr <= '0;
      config_data <= '0;
      config_write <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
      word_count <= '0;
`ifdef PE_CONFIG_READBACK_EN
      config_read <= 1'b0;
`endif
    end else begin
      config_write <= 1'b0;
`ifdef PE_CONFIG_READBACK_EN
      config_read <= 1'b0;
`endif
      last_seen <= !go && last_next;
      cfg_ready <= go || (busy && cnt_next != DEPTH[AW:0] && !last_next);
      case (state)
        IDLE, DONE: if (go) begin
          state <= TRST;
          tmr <= 16'(TILE_RST_CYCLES - 1);
          tile_reset <= 1'b1;
          busy <= 1'b1;
          done <= 1'b0;
          error <= 1'b0;
          word_count <= '0;
        end
        TRST: if (tmr == '0) begin
          state <= WAIT;
          tile_reset <= 1'b0;
        end else tmr <= tmr - 16'd1;
        WAIT: if (!empty) begin
          state <= WRITE;
          config_write <= 1'b1;
          config_addr <= rd_word.addr;
          config_data <= rd_word.data;
          cur_last <= rd_word.last;
          if (word_count != '1) word_count <= word_count + 16'd1;
        end
`ifdef PE_CONFIG_READBACK_EN
        WRITE: begin
          state <= READ;
          config_read <= 1'b1;
        end
        READ: state <= CHECK;
        CHECK: begin
          if (read_data != config_data) error <= 1'b1;
`else
        WRITE: begin
`endif
          if (SETTLE_CYCLES > 0) begin
            state <= SETTLE;
            tmr <= 16'(SETTLE_CYCLES - 1);
          end else if (cur_last) begin
            state <= DONE;
            busy <= 1'b0;
            done <= 1'b1;
          end else state <= WAIT;
        end
        SETTLE: if (tmr != '0) tmr <= tmr - 16'd1;
          else if (cur_last) begin
            state <= DONE;
            busy <= 1'b0;
            done <= 1'b1;
          end else state <= WAIT;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pe_config_sequencer.sv
// tb_pe_config_sequencer: scoreboard bench; accepted host words are queued as expected tile writes.
module tb_pe_config_sequencer;
  logic clk_in = 0, reset = 0, start = 0, cfg_valid = 0, cfg_last = 0, bad_tile = 0;
  logic [31:0] cfg_addr = 0, cfg_data = 0, read_data, config_addr, config_data;
  logic cfg_ready, tile_reset, config_write, config_read, busy, done, error;
  logic [15:0] word_count;
  logic [63:0] exp_q[$], obs_q[$];
  logic [63:0] e, o;
  int checks = 0, errors = 0, nwrites = 0, nreads = 0, ntrst = 0, stalls = 0;
  bit ok, all_ok;

  always #5 clk_in = ~clk_in;
  assign read_data = (bad_tile && config_addr == 32'h2) ? 32'hDEAD : config_data;

  pe_config_sequencer dut (
    .clk_in(clk_in), .reset(reset), .start(start), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_last(cfg_last), .tile_reset(tile_reset),
    .config_addr(config_addr), .config_data(config_data), .config_write(config_write),
    .config_read(config_read), .read_data(read_data), .busy(busy), .done(done), .error(error),
    .word_count(word_count)
  );

  always @(negedge clk_in) begin
    if (config_write) begin
      obs_q.push_back({config_addr, config_data});
      nwrites++;
    end
    if (config_read) nreads++;
    if (tile_reset) ntrst++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(negedge clk_in);
    #1;
  endtask

  task automatic new_session();
    exp_q.delete();
    obs_q.delete();
    nwrites = 0; nreads = 0; ntrst = 0; stalls = 0;
    start = 1;
    step();
    start = 0;
  endtask

  task automatic host_send(input logic [31:0] a, d, input logic l, input int budget, output bit acc);
    cfg_valid = 1; cfg_addr = a; cfg_data = d; cfg_last = l; acc = 0;
    for (int i = 0; i < budget && !acc; i++) begin
      acc = cfg_ready;
      if (!acc) stalls++;
      step();
    end
    cfg_valid = 0; cfg_last = 0;
    if (acc) exp_q.push_back({a, d});
  endtask

  task automatic wait_done(input int budget, output bit got);
    got = 0;
    for (int i = 0; i < budget && !got; i++) begin
      step();
      got = done;
    end
  endtask

  task automatic wait_writes(input int n, input int budget, output bit got);
    got = nwrites >= n;
    for (int i = 0; i < budget && !got; i++) begin
      step();
      got = nwrites >= n;
    end
  endtask

  task automatic test_reset();
    reset = 0;
    step();
    step();
    checks++;
    if ({cfg_ready, tile_reset, config_write, config_read, busy, done, error} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 0000000", {cfg_ready, tile_reset, config_write, config_read, busy, done, error});
    end
    checks++;
    if ({config_addr, config_data, word_count} !== 80'b0) begin
      errors++;
      $display("FAIL reset_bus got addr=%h data=%h wc=%0d want 0", config_addr, config_data, word_count);
    end
    reset = 1;
    step();
    checks++;
    if (cfg_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_ready got ready=%b busy=%b want 0 0", cfg_ready, busy);
    end
  endtask

  task automatic test_basic();
    new_session();
    checks++;
    if (busy !== 1'b1 || tile_reset !== 1'b1) begin
      errors++;
      $display("FAIL basic_start got busy=%b trst=%b want 1 1", busy, tile_reset);
    end
    all_ok = 1;
    host_send(32'h1, 32'hA, 0, 20, ok); all_ok &= ok;
    host_send(32'h2, 32'hB, 0, 20, ok); all_ok &= ok;
    host_send(32'h3, 32'hC, 1, 20, ok); all_ok &= ok;
    wait_done(100, ok);
    checks++;
    if (!(ok && all_ok)) begin
      errors++;
      $display("FAIL basic_progress got accepted=%b done=%b want 1 1", all_ok, ok);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL basic_write got %h want %h", o, e);
      end
    end
    checks++;
    if (exp_q.size() + obs_q.size() != 0 || ntrst != 3 || word_count !== 16'd3 || busy !== 1'b0 || error !== 1'b0) begin
      errors++;
      $display("FAIL basic_end got left=%0d trst=%0d wc=%0d busy=%b err=%b want 0 3 3 0 0", exp_q.size() + obs_q.size(), ntrst, word_count, busy, error);
    end
  endtask

  task automatic test_back_to_back();
    new_session();
    all_ok = 1;
    for (int i = 0; i < 6; i++) begin
      host_send(32'h10 + i, 32'h100 + 32'h11 * i, i == 5, 50, ok);
      all_ok &= ok;
    end
    checks++;
    if (!all_ok || stalls == 0) begin
      errors++;
      $display("FAIL b2b_flow got accepted=%b stalls=%0d want 1 >0", all_ok, stalls);
    end
    wait_done(200, ok);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL b2b_write got %h want %h", o, e);
      end
    end
    checks++;
    if (!ok || exp_q.size() + obs_q.size() != 0 || word_count !== 16'd6) begin
      errors++;
      $display("FAIL b2b_end got done=%b left=%0d wc=%0d want 1 0 6", ok, exp_q.size() + obs_q.size(), word_count);
    end
  endtask

  task automatic test_gap();
    new_session();
    host_send(32'h20, 32'h200, 0, 20, ok);
    host_send(32'h21, 32'h201, 0, 20, ok);
    wait_writes(2, 50, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL gap_writes got %0d want 2", nwrites);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (config_write !== 1'b0 || config_addr !== 32'h21 || config_data !== 32'h201 || busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL gap_hold got wr=%b addr=%h data=%h busy=%b done=%b want 0 21 201 1 0", config_write, config_addr, config_data, busy, done);
      end
    end
    host_send(32'h22, 32'h202, 1, 20, ok);
    wait_done(100, ok);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL gap_write got %h want %h", o, e);
      end
    end
    checks++;
    if (!ok || exp_q.size() + obs_q.size() != 0 || word_count !== 16'd3) begin
      errors++;
      $display("FAIL gap_end got done=%b left=%0d wc=%0d want 1 0 3", ok, exp_q.size() + obs_q.size(), word_count);
    end
  endtask

  task automatic test_reset_mid();
    new_session();
    host_send(32'h30, 32'h300, 0, 20, ok);
    host_send(32'h31, 32'h301, 0, 20, ok);
    host_send(32'h32, 32'h302, 1, 20, ok);
    wait_writes(2, 50, ok);
    step();
    reset = 0;
    #1;
    checks++;
    if ({cfg_ready, tile_reset, config_write, config_read, busy, done, error} !== 7'b0 || {config_addr, config_data, word_count} !== 80'b0) begin
      errors++;
      $display("FAIL midreset_out got flags=%b addr=%h data=%h wc=%0d want 0", {cfg_ready, tile_reset, config_write, config_read, busy, done, error}, config_addr, config_data, word_count);
    end
    for (int i = 0; i < 4; i++) step();
    reset = 1;
    for (int i = 0; i < 4; i++) step();
    while (exp_q.size() > 1 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL midreset_write got %h want %h", o, e);
      end
    end
    checks++;
    if (nwrites != 2 || obs_q.size() != 0 || done !== 1'b0) begin
      errors++;
      $display("FAIL midreset_drop got writes=%0d done=%b want 2 0", nwrites, done);
    end
    new_session();
    checks++;
    if (word_count !== 16'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL restart got wc=%0d busy=%b want 0 1", word_count, busy);
    end
    host_send(32'h33, 32'h303, 1, 20, ok);
    wait_done(100, ok);
    checks++;
    e = exp_q.pop_front();
    o = obs_q.size() > 0 ? obs_q.pop_front() : 64'hx;
    if (!ok || o !== e || word_count !== 16'd1) begin
      errors++;
      $display("FAIL restart_end got done=%b write=%h wc=%0d want 1 %h 1", ok, o, word_count, e);
    end
  endtask

  task automatic test_ignore();
    new_session();
    host_send(32'h40, 32'h400, 0, 20, ok);
    host_send(32'h41, 32'h401, 0, 20, ok);
    host_send(32'h42, 32'h402, 1, 20, ok);
    checks++;
    if (cfg_ready !== 1'b0) begin
      errors++;
      $display("FAIL ignore_ready got %b want 0", cfg_ready);
    end
    host_send(32'h99, 32'h999, 0, 4, ok);
    checks++;
    if (ok) begin
      errors++;
      $display("FAIL ignore_extra got accepted=1 want 0");
    end
    for (int i = 0; i < 20 && config_write !== 1'b1; i++) step();
    start = 1;
    step();
    start = 0;
    wait_done(100, ok);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL ignore_write got %h want %h", o, e);
      end
    end
    checks++;
    if (!ok || exp_q.size() + obs_q.size() != 0 || ntrst != 3 || word_count !== 16'd3) begin
      errors++;
      $display("FAIL ignore_end got done=%b left=%0d trst=%0d wc=%0d want 1 0 3 3", ok, exp_q.size() + obs_q.size(), ntrst, word_count);
    end
  endtask

`ifdef PE_CONFIG_READBACK_EN
  task automatic test_readback();
    bad_tile = 1;
    new_session();
    host_send(32'h1, 32'hA, 0, 20, ok);
    host_send(32'h2, 32'hB, 0, 20, ok);
    host_send(32'h3, 32'hC, 1, 20, ok);
    wait_writes(1, 50, ok);
    checks++;
    if (!ok || error !== 1'b0) begin
      errors++;
      $display("FAIL rb_first got writes=%0d err=%b want 1 0", nwrites, error);
    end
    wait_done(200, ok);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL rb_write got %h want %h", o, e);
      end
    end
    checks++;
    if (!ok || nreads != 3 || error !== 1'b1 || word_count !== 16'd3) begin
      errors++;
      $display("FAIL rb_end got done=%b reads=%0d err=%b wc=%0d want 1 3 1 3", ok, nreads, error, word_count);
    end
    bad_tile = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_gap();
    test_reset_mid();
    test_ignore();
`ifdef PE_CONFIG_READBACK_EN
    test_readback();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pe_config_sequencer.md
# pe_config_sequencer

Sequences configuration of a PE tile. Accepts a stream of (address, data) configuration words, e.g. parsed from a `.bsa` config-lines file, into a small FIFO. It pulses the tile reset, then replays each word onto the tile's 32-bit `config_addr`/`config_data` bus with a one-cycle write strobe and programmable settle gaps. It reports progress, completion and errors to the host or testbench. It sits between the config-file reader and the `top` tile instance.

## Interface
Parameters:
- `DEPTH`, 4, FIFO entries; power of two, ≥2.
- `SETTLE_CYCLES`, 1, idle cycles after each write; 0 allowed.
- `TILE_RST_CYCLES`, 3, cycles `tile_reset` is held high per session; ≥1.

Ports:
- `clk_in`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low.
- `start`  in  1  single-cycle request to begin a session.
- `cfg_valid`  in  1  host word valid.
- `cfg_ready`  out  1  sequencer can accept a word.
- `cfg_addr`  in  32  host config address.
- `cfg_data`  in  32  host config data.
- `cfg_last`  in  1  marks the final word of a session.
- `tile_reset`  out  1  active-high reset to the tile.
- `config_addr`  out  32  tile config address.
- `config_data`  out  32  tile config data.
- `config_write`  out  1  one-cycle write strobe.
- `config_read`  out  1  one-cycle readback strobe; only driven with the macro.
- `read_data`  in  32  tile readback data.
- `busy`  out  1  high from `start` acceptance until DONE.
- `done`  out  1  high in DONE.
- `error`  out  1  sticky error flag.
- `word_count`  out  16  writes issued this session.

## Operation
- FSM states: IDLE, TRST, WAIT, WRITE, SETTLE, DONE. With the macro, READ and CHECK are added.
- IDLE/DONE + `start` → TRST. Entering TRST clears `word_count`, `error` and `done`, and sets `busy`. `start` is ignored in every other state.
- TRST: `tile_reset`=1 for exactly `TILE_RST_CYCLES` cycles, then → WAIT.
- WAIT: if the FIFO is non-empty, pop → WRITE. Otherwise stay.
- WRITE: `config_write`=1 for 1 cycle with the popped addr/data. `word_count` increments, saturating at 0xFFFF. Then → SETTLE, or → DONE if `SETTLE_CYCLES`=0 and the word had `last` set, or → WAIT if `SETTLE_CYCLES`=0 and it did not.
- SETTLE: counts `SETTLE_CYCLES`. Then → DONE if the popped word had `last`, else → WAIT.
- `cfg_ready` = (state ∉ {IDLE, DONE}) ∧ FIFO not full ∧ `last` not yet accepted this session. Words are accepted during TRST.
- Handshake: a transfer occurs on an edge with `cfg_valid`∧`cfg_ready`. The host must hold its signals until the transfer. No bypass: a full FIFO deasserts `cfg_ready`, so push and pop are never simultaneous when full.
- A handshake with `cfg_valid`=1 while `cfg_ready`=0 is not an error.
- `config_addr`/`config_data` hold their last written value between strobes.
- Asynchronous reset mid-session: the FIFO is emptied, the FSM goes to IDLE, and all outputs are cleared. No partial write strobe may appear.

## Timing
- All outputs are registered.
- Reset values: `cfg_ready`=0, `tile_reset`=0, `config_addr`=0, `config_data`=0, `config_write`=0, `config_read`=0, `busy`=0, `done`=0, `error`=0, `word_count`=0.
- `start` sampled at edge k: `tile_reset` and `busy` are high from k+1. `tile_reset` falls at k+1+`TILE_RST_CYCLES`.
- Minimum latency from word acceptance to its `config_write` is 2 cycles (FIFO write, then pop→WRITE).
- Write-to-write spacing with the FIFO full: 2+`SETTLE_CYCLES` cycles, because WAIT takes 1 cycle.
- `done` rises the cycle after the final WRITE/SETTLE completes. `busy` falls in the same cycle.

## Configuration
- Macro: `PE_CONFIG_READBACK_EN`.
- Defined: WRITE → READ. READ drives `config_read`=1 for 1 cycle at the same address. CHECK follows, comparing `read_data` with the written data. A mismatch sets `error` (sticky). The FSM then continues to SETTLE. Write spacing grows by 2 cycles.
- Undefined: READ and CHECK do not exist, `config_read` is tied 0, `read_data` is unused, and `error` stays 0.

## Structure
- Package `pe_config_pkg`:
  - `CFG_ADDR_W`=32, `CFG_DATA_W`=32, `WORD_COUNT_W`=16.
  - State enum `cfg_seq_state_t`.
  - Packed struct `cfg_word_t` {addr, data, last}.
- Sub-module `pe_config_fifo`: synchronous FIFO of `cfg_word_t` with `DEPTH` entries. It provides full/empty flags, uses an async active-low clear, and has wrap-around pointers with an extra MSB.

## Test plan
- Reset then `start` with 3 words streamed back-to-back (0x1/0xA, 0x2/0xB, 0x3/0xC, last on the third) → `tile_reset` high for 3 cycles, three `config_write` pulses in order, `word_count`=3, `done`=1, `busy`=0.
- `DEPTH`=4 with 6 words offered continuously → `cfg_ready` drops while the FIFO holds 4, no word is lost or duplicated, and the write order matches the input.
- Host gaps (`cfg_valid` low for 5 cycles mid-stream) → FSM sits in WAIT, and `config_addr`/`config_data` hold their previous value.
- Assert `reset` low between the second and third write → all outputs return to reset values immediately. A following `start` restarts with `word_count`=0.
- `start` pulsed during WRITE, and words offered after `last` → both are ignored, and `cfg_ready`=0 after `last` is accepted.
- With `PE_CONFIG_READBACK_EN`, a tile returns 0xDEAD for address 0x2 instead of 0xB → `config_read` pulses once per word, `error`=1 after the second word, and the session still completes with `word_count`=3.
